// File: rtl/subckt_vector_driver.sv
// subckt_vector_driver: LFSR vector source and serial response compactor
// Optional signature comparator enabled by defining SIG_COMPARE_EN.
module subckt_vector_driver #(
    parameter int VEC_W    = 4,
    parameter int NUM_VEC  = 16,
    parameter int CAPT_DLY = 2
`ifdef SIG_COMPARE_EN
    ,
    parameter logic [15:0] GOLDEN_SIG = 16'h0000
`endif
) (
    input  logic             I1470_clk,
    input  logic             I1477_rst,
    input  logic             start,
    input  logic             seed_load,
    input  logic [15:0]      seed_in,
    input  logic             resp_in,
    output logic [VEC_W-1:0] vec_out,
    output logic             busy,
    output logic             done,
    output logic [15:0]      vec_count,
    output logic [15:0]      signature
`ifdef SIG_COMPARE_EN
    ,
    output logic             sig_fail
`endif
);

    localparam int CW = (CAPT_DLY > 1) ? $clog2(CAPT_DLY) : 1;
    localparam logic [CW-1:0] WAIT_LAST =
        CW'((CAPT_DLY > 0) ? CAPT_DLY - 1 : 0);
    localparam logic [15:0] NV = 16'(NUM_VEC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_WAIT,
        S_CAPT,
        S_DONE
    } state_t;

    state_t          state;
    state_t          nxt;
    logic [15:0]     lfsr;
    logic [CW-1:0]   wcnt;
    logic [15:0]     cnt_inc;
    logic            last;
    logic [15:0]     sig_nxt;
    logic [15:0]     lfsr_nxt;
    logic [15:0]     seed_fix;

    assign cnt_inc  = vec_count + 16'd1;
    assign last     = (cnt_inc == NV);
    assign sig_nxt  = {signature[14:0],
                       signature[15] ^ signature[13] ^
                       signature[12] ^ signature[10] ^ resp_in};
    assign lfsr_nxt = {lfsr[14:0],
                       lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    // a zero seed would lock the LFSR, so substitute 1
    assign seed_fix = (seed_in == 16'd0) ? 16'd1 : seed_in;

    // state register
    always_ff @(posedge I1470_clk) begin
        if (I1477_rst) state <= S_IDLE;
        else           state <= nxt;
    end

    // next-state and status decode
    always_comb begin
        nxt  = state;
        busy = 1'b0;
        done = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) nxt = S_APPLY;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) nxt = S_APPLY;
            end
            S_APPLY: begin
                busy = 1'b1;
                nxt  = (CAPT_DLY == 0) ? S_CAPT : S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (wcnt == WAIT_LAST) nxt = S_CAPT;
            end
            S_CAPT: begin
                busy = 1'b1;
                nxt  = last ? S_DONE : S_APPLY;
            end
            default: nxt = S_IDLE;
        endcase
    end

    // LFSR, vector, settle counter, signature and count
    always_ff @(posedge I1470_clk) begin
        if (I1477_rst) begin
            lfsr      <= 16'h0001;
            vec_out   <= '0;
            wcnt      <= '0;
            vec_count <= 16'd0;
            signature <= 16'd0;
`ifdef SIG_COMPARE_EN
            sig_fail  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (seed_load) lfsr <= seed_fix;
                    if (start) begin
                        vec_count <= 16'd0;
                        signature <= 16'd0;
`ifdef SIG_COMPARE_EN
                        sig_fail  <= 1'b0;
`endif
                    end
                end
                S_APPLY: begin
                    vec_out <= lfsr[VEC_W-1:0];
                    wcnt    <= '0;
                end
                S_WAIT: begin
                    wcnt <= wcnt + CW'(1);
                end
                S_CAPT: begin
                    signature <= sig_nxt;
                    lfsr      <= lfsr_nxt;
                    vec_count <= cnt_inc;
                    if (last) begin
                        vec_out  <= '0;
`ifdef SIG_COMPARE_EN
                        sig_fail <= (sig_nxt != GOLDEN_SIG);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
